clkdiv_multi: RTL and testbench

//  NCH-channel programmable clock divider producing divided clock-enable / clock-like outputs from clk.

---
 rtl/clkdiv_multi.sv | 113 +++++++++++
 tb/tb_clkdiv_multi.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : clkdiv_multi
// Purpose  : NCH-channel runtime-programmable clock divider with square/pulse
//            outputs, glitch-free divisor updates and a shared phase-align strobe.
// Revision : 1.0 - initial release
// ============================================================================
module clkdiv_multi #(
    parameter int NCH     = 4,
    parameter int W       = 16,
    parameter int DEF_DIV = 2,
    localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] en,
    input  logic           sync,
    input  logic           div_wr,
    input  logic [CHW-1:0] div_ch,
    input  logic [W-1:0]   div_val,
    input  logic           div_mode,
    output logic [NCH-1:0] out,
    output logic [NCH-1:0] tick
);

    localparam logic [W-1:0] c_def_div = (DEF_DIV < 2) ? W'(2) : W'(DEF_DIV);

    logic [W-1:0] w_div_clamped;
    assign w_div_clamped = (div_val < W'(2)) ? W'(2) : div_val;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [W-1:0] r_count;
        logic [W-1:0] r_div;
        logic [W-1:0] r_sh_div;
        logic         r_mode;
        logic         r_sh_mode;
        logic         r_pending;
        logic         r_running;
        logic         r_p;
        logic         r_n;
        logic         r_tick;

        logic         w_hit;
        logic         w_wrap;
        logic [W-1:0] w_count_inc;
        logic         w_p_next;

        assign w_hit       = div_wr && (int'(div_ch) == gi);
        // Terminal compare precedes the increment, so D = 2^W-1 never overflows.
        assign w_wrap      = !r_running || (r_count == (r_div - W'(1))) || sync;
        assign w_count_inc = r_count + W'(1);
        assign w_p_next    = w_count_inc < (r_div >> 1);

        always_ff @(posedge clk) begin
            if (reset) begin
                r_count   <= '0;
                r_div     <= c_def_div;
                r_sh_div  <= c_def_div;
                r_mode    <= 1'b0;
                r_sh_mode <= 1'b0;
                r_pending <= 1'b0;
                r_running <= 1'b0;
                r_p       <= 1'b0;
                r_tick    <= 1'b0;
            end else begin
                if (en[gi]) begin
                    if (w_wrap) begin
                        r_count   <= '0;
                        r_tick    <= 1'b1;
                        r_p       <= 1'b1;
                        r_running <= 1'b1;
                        if (r_pending) begin
                            r_div     <= r_sh_div;
                            r_mode    <= r_sh_mode;
                            r_pending <= 1'b0;
                        end
                    end else begin
                        r_count <= w_count_inc;
                        r_tick  <= 1'b0;
                        r_p     <= w_p_next;
                    end
                end else begin
                    r_count   <= '0;
                    r_p       <= 1'b0;
                    r_tick    <= 1'b0;
                    r_running <= 1'b0;
                    if (r_pending) begin
                        r_div     <= r_sh_div;
                        r_mode    <= r_sh_mode;
                        r_pending <= 1'b0;
                    end
                end
                // A write landing on a boundary cycle stays queued for the next one.
                if (w_hit) begin
                    r_sh_div  <= w_div_clamped;
                    r_sh_mode <= div_mode;
                    r_pending <= 1'b1;
                end
            end
        end

        // Half-cycle delayed copy of p; supplies the extra half for odd divisors.
        always_ff @(negedge clk) begin
            r_n <= r_p;
        end

        assign out[gi]  = r_mode ? r_tick : (r_p | (r_n & r_div[0] & r_running));
        assign tick[gi] = r_tick;
    end

endmodule
`default_nettype wire

// File: tb/tb_clkdiv_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_clkdiv_multi
// Purpose  : Self-checking bench for clkdiv_multi (table rows + directed periods).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clkdiv_multi;

    localparam int NCH     = 3;
    localparam int W       = 8;
    localparam int DEF_DIV = 2;
    localparam int CHW     = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] en;
    logic           sync;
    logic           div_wr;
    logic [CHW-1:0] div_ch;
    logic [W-1:0]   div_val;
    logic           div_mode;
    logic [NCH-1:0] out;
    logic [NCH-1:0] tick;

    clkdiv_multi #(.NCH(NCH), .W(W), .DEF_DIV(DEF_DIV)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .sync    (sync),
        .div_wr  (div_wr),
        .div_ch  (div_ch),
        .div_val (div_val),
        .div_mode(div_mode),
        .out     (out),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0] out;
        logic [NCH-1:0] tick;
    } exp_t;

    typedef struct packed {
        bit             rst;
        bit [NCH-1:0]   en;
        bit             sync;
        bit             wr;
        bit [CHW-1:0]   ch;
        bit [W-1:0]     val;
        bit             mode;
        int             cycles;
        int             e0;
        int             e1;
        int             e2;
    } row_t;

    exp_t q_pos[$];
    exp_t q_neg[$];
    exp_t e_pos;
    exp_t e_neg;
    int   n_cmp = 0;
    int   n_bad = 0;

    int   m_cnt  [NCH];
    int   m_d    [NCH];
    int   m_shd  [NCH];
    bit   m_run  [NCH];
    bit   m_mode [NCH];
    bit   m_shm  [NCH];
    bit   m_pend [NCH];

    task automatic check_vec(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference behaviour: expected outputs derived from period position in half-cycles.
    task automatic model_step();
        exp_t ep;
        exp_t en_;
        bit   hit;
        ep  = '0;
        en_ = '0;
        for (int c = 0; c < NCH; c++) begin
            if (reset) begin
                m_cnt[c]  = 0;
                m_run[c]  = 0;
                m_pend[c] = 0;
                m_mode[c] = 0;
                m_d[c]    = (DEF_DIV < 2) ? 2 : DEF_DIV;
            end else begin
                hit = div_wr && (int'(div_ch) == c);
                if (en[c]) begin
                    if (!m_run[c] || m_cnt[c] == m_d[c] - 1 || sync) begin
                        m_cnt[c] = 0;
                        m_run[c] = 1;
                        if (m_pend[c]) begin
                            m_d[c]    = m_shd[c];
                            m_mode[c] = m_shm[c];
                            m_pend[c] = 0;
                        end
                    end else begin
                        m_cnt[c] = m_cnt[c] + 1;
                    end
                end else begin
                    m_cnt[c] = 0;
                    m_run[c] = 0;
                    if (m_pend[c]) begin
                        m_d[c]    = m_shd[c];
                        m_mode[c] = m_shm[c];
                        m_pend[c] = 0;
                    end
                end
                if (hit) begin
                    m_shd[c]  = (int'(div_val) < 2) ? 2 : int'(div_val);
                    m_shm[c]  = div_mode;
                    m_pend[c] = 1;
                end
            end
            ep.tick[c]  = m_run[c] && (m_cnt[c] == 0);
            en_.tick[c] = ep.tick[c];
            ep.out[c]   = m_mode[c] ? ep.tick[c] : (m_run[c] && (2 * m_cnt[c] < m_d[c]));
            en_.out[c]  = m_mode[c] ? ep.tick[c] : (m_run[c] && (2 * m_cnt[c] + 1 < m_d[c]));
        end
        q_pos.push_back(ep);
        q_neg.push_back(en_);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #2;
    endtask

    always begin
        @(posedge clk);
        #1;
        if (q_pos.size() != 0) begin
            e_pos = q_pos.pop_front();
            check_vec("out_pos", out, e_pos.out);
            check_vec("tick_pos", tick, e_pos.tick);
        end
    end

    always begin
        @(negedge clk);
        #1;
        if (q_neg.size() != 0) begin
            e_neg = q_neg.pop_front();
            check_vec("out_neg", out, e_neg.out);
            check_vec("tick_neg", tick, e_neg.tick);
        end
    end

    function automatic row_t mk(input bit rst, input bit [NCH-1:0] e, input bit sy, input bit wr,
                                input int ch, input int val, input bit mode, input int cyc,
                                input int x0, input int x1, input int x2);
        row_t r;
        r.rst    = rst;
        r.en     = e;
        r.sync   = sy;
        r.wr     = wr;
        r.ch     = ch[CHW-1:0];
        r.val    = val[W-1:0];
        r.mode   = mode;
        r.cycles = cyc;
        r.e0     = x0;
        r.e1     = x1;
        r.e2     = x2;
        return r;
    endfunction

    function automatic int row_exp(input row_t r, input int c);
        case (c)
            0:       return r.e0;
            1:       return r.e1;
            default: return r.e2;
        endcase
    endfunction

    task automatic write_cfg(input int ch, input int val, input bit mode);
        div_wr   = 1'b1;
        div_ch   = ch[CHW-1:0];
        div_val  = val[W-1:0];
        div_mode = mode;
        step();
        div_wr   = 1'b0;
    endtask

    task automatic wait_tick(input int c, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (tick[c]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called on a tick cycle; counts cycles to the next tick and high half-cycles.
    task automatic measure_period(input int c, input int limit, output int per, output int highs);
        per   = 0;
        highs = 0;
        while (per < limit) begin
            highs += int'(out[c]);
            #4;
            highs += int'(out[c]);
            per++;
            step();
            if (tick[c]) break;
        end
    endtask

    row_t tbl [28];
    int   tcnt [NCH];
    bit   ok;
    int   per;
    int   highs;
    int   n;

    initial begin
        tbl[0]  = mk(1, 3'b000, 0, 0, 0, 0,   0, 2,  0,  0,  0);
        tbl[1]  = mk(0, 3'b001, 0, 0, 0, 0,   0, 8,  4,  0,  0);
        tbl[2]  = mk(0, 3'b001, 0, 1, 1, 4,   0, 1,  1,  0,  0);
        tbl[3]  = mk(0, 3'b011, 0, 0, 0, 0,   0, 12, 6,  3,  0);
        tbl[4]  = mk(0, 3'b011, 0, 1, 2, 5,   0, 1,  0,  1,  0);
        tbl[5]  = mk(0, 3'b111, 0, 0, 0, 0,   0, 15, 8,  3,  3);
        tbl[6]  = mk(0, 3'b111, 0, 1, 0, 4,   0, 1,  -1, -1, -1);
        tbl[7]  = mk(0, 3'b111, 0, 0, 0, 0,   0, 6,  -1, -1, -1);
        tbl[8]  = mk(0, 3'b111, 0, 1, 0, 6,   0, 1,  -1, -1, -1);
        tbl[9]  = mk(0, 3'b111, 0, 0, 0, 0,   0, 14, -1, -1, -1);
        tbl[10] = mk(0, 3'b111, 0, 1, 0, 3,   0, 1,  -1, -1, -1);
        tbl[11] = mk(0, 3'b111, 0, 1, 1, 7,   0, 1,  -1, -1, -1);
        tbl[12] = mk(0, 3'b111, 0, 0, 0, 0,   0, 20, -1, -1, -1);
        tbl[13] = mk(0, 3'b111, 1, 0, 0, 0,   0, 1,  1,  1,  1);
        tbl[14] = mk(0, 3'b111, 0, 0, 0, 0,   0, 21, 7,  3,  4);
        tbl[15] = mk(0, 3'b101, 1, 0, 0, 0,   0, 1,  1,  0,  1);
        tbl[16] = mk(0, 3'b111, 0, 0, 0, 0,   0, 1,  0,  1,  0);
        tbl[17] = mk(0, 3'b111, 0, 1, 1, 0,   0, 1,  -1, -1, -1);
        tbl[18] = mk(0, 3'b111, 0, 0, 0, 0,   0, 20, -1, -1, -1);
        tbl[19] = mk(0, 3'b111, 0, 1, 2, 1,   0, 1,  -1, -1, -1);
        tbl[20] = mk(0, 3'b111, 0, 1, 0, 3,   1, 1,  -1, -1, -1);
        tbl[21] = mk(0, 3'b111, 0, 0, 0, 0,   0, 20, -1, -1, -1);
        tbl[22] = mk(0, 3'b111, 1, 0, 0, 0,   0, 1,  1,  1,  1);
        tbl[23] = mk(0, 3'b111, 0, 0, 0, 0,   0, 12, 4,  6,  6);
        tbl[24] = mk(0, 3'b111, 0, 1, 3, 9,   1, 1,  0,  0,  0);
        tbl[25] = mk(0, 3'b111, 0, 0, 0, 0,   0, 12, 4,  6,  6);
        tbl[26] = mk(1, 3'b111, 0, 0, 0, 0,   0, 1,  0,  0,  0);
        tbl[27] = mk(0, 3'b111, 0, 0, 0, 0,   0, 4,  2,  2,  2);

        reset    = 1'b1;
        en       = '0;
        sync     = 1'b0;
        div_wr   = 1'b0;
        div_ch   = '0;
        div_val  = '0;
        div_mode = 1'b0;

        for (int r = 0; r < 28; r++) begin
            reset    = tbl[r].rst;
            en       = tbl[r].en;
            sync     = tbl[r].sync;
            div_wr   = tbl[r].wr;
            div_ch   = tbl[r].ch;
            div_val  = tbl[r].val;
            div_mode = tbl[r].mode;
            for (int c = 0; c < NCH; c++) tcnt[c] = 0;
            for (int k = 0; k < tbl[r].cycles; k++) begin
                step();
                for (int c = 0; c < NCH; c++) tcnt[c] += int'(tick[c]);
                sync   = 1'b0;
                div_wr = 1'b0;
            end
            for (int c = 0; c < NCH; c++) begin
                if (row_exp(tbl[r], c) >= 0)
                    check_int($sformatf("row%0d_ticks_ch%0d", r, c), tcnt[c], row_exp(tbl[r], c));
            end
        end

        // Odd divisor, square mode: 5-cycle period, high for 5 half-cycles.
        write_cfg(2, 5, 1'b0);
        wait_tick(2, 12, ok);
        check_int("d5_first_tick", int'(ok), 1);
        measure_period(2, 20, per, highs);
        check_int("d5_period", per, 5);
        check_int("d5_high_halves", highs, 5);

        // Pulse mode, D=3: high one full cycle out of three.
        write_cfg(0, 3, 1'b1);
        wait_tick(0, 12, ok);
        check_int("pulse3_first_tick", int'(ok), 1);
        measure_period(0, 20, per, highs);
        check_int("pulse3_period", per, 3);
        check_int("pulse3_high_halves", highs, 2);

        // Divisor change mid-period: D=4 period completes, then D=6.
        write_cfg(1, 4, 1'b0);
        wait_tick(1, 12, ok);
        check_int("d4_first_tick", int'(ok), 1);
        write_cfg(1, 6, 1'b0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            n++;
            if (tick[1]) break;
        end
        check_int("d4_tail_cycles", n, 3);
        measure_period(1, 20, per, highs);
        check_int("d6_period", per, 6);
        check_int("d6_high_halves", highs, 6);

        // Largest divisor for the counter width.
        write_cfg(2, 255, 1'b0);
        wait_tick(2, 12, ok);
        check_int("d255_first_tick", int'(ok), 1);
        measure_period(2, 300, per, highs);
        check_int("d255_period", per, 255);
        check_int("d255_high_halves", highs, 255);

        #12;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
